// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - opcodes, ctrl bit map, class and state types for datapath_ctrl
package datapath_ctrl_pkg;

  localparam int OP_W   = 5;
  localparam int CTRL_W = 25;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam int C_PCOUT    = 0;
  localparam int C_ZHIGHOUT = 1;
  localparam int C_ZLOWOUT  = 2;
  localparam int C_MDROUT   = 3;
  localparam int C_HIOUT    = 4;
  localparam int C_LOOUT    = 5;
  localparam int C_MARIN    = 6;
  localparam int C_PCIN     = 7;
  localparam int C_MDRIN    = 8;
  localparam int C_IRIN     = 9;
  localparam int C_YIN      = 10;
  localparam int C_INCPC    = 11;
  localparam int C_READ     = 12;
  localparam int C_WRITE    = 13;
  localparam int C_GRA      = 14;
  localparam int C_GRB      = 15;
  localparam int C_GRC      = 16;
  localparam int C_RIN      = 17;
  localparam int C_ROUT     = 18;
  localparam int C_BAOUT    = 19;
  localparam int C_COUT     = 20;
  localparam int C_HIIN     = 21;
  localparam int C_LOIN     = 22;
  localparam int C_ZHIGHIN  = 23;
  localparam int C_ZLOWIN   = 24;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_NOP, CL_HALT, CL_BAD
  } op_class_e;

  typedef enum logic [4:0] {
    S_IDLE, S_T0, S_T1, S_T2,
    S_R3, S_R4, S_R5,
    S_I3, S_I4, S_I5,
    S_M3, S_M4, S_M5, S_M6,
    S_U3, S_U4,
    S_A3, S_A4, S_LDI5,
    S_LD5, S_LD6, S_LD7,
    S_ST5, S_ST6, S_ST7,
    S_HALT
  } state_e;

  function automatic logic [CTRL_W-1:0] cb(int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/datapath_ctrl_opcode_class_dec.sv
// rtl/datapath_ctrl_opcode_class_dec.sv - combinational opcode to instruction-class decoder
module opcode_class_dec
  import datapath_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output op_class_e       cls_o
);

  always_comb begin
    cls_o = CL_BAD;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      cls_o = CL_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:             cls_o = CL_IMM;
      OP_MUL, OP_DIV:                       cls_o = CL_MULDIV;
      OP_NEG, OP_NOT:                       cls_o = CL_UNARY;
      OP_LD:                                cls_o = CL_LD;
      OP_LDI:                               cls_o = CL_LDI;
      OP_ST:                                cls_o = CL_ST;
      OP_NOP:                               cls_o = CL_NOP;
      OP_HALT:                              cls_o = CL_HALT;
      default:                              cls_o = CL_BAD;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - hard-wired Moore control unit sequencing the single-bus DataPath
// Define ILLEGAL_OP_TRAP_EN to halt and flag Illegal on undefined opcodes.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int IR_W  = 32,
  parameter int OPC_W = 5
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [IR_W-1:0]   IR,
  input  logic              Mem_ready,
  input  logic              Stop,
  output logic [CTRL_W-1:0] ctrl,
  output logic [OPC_W-1:0]  alu_op,
  output logic              Run,
  output logic              Illegal
);

  state_e             state_q, state_d;
  op_class_e          ir_cls, cls_q;
  logic [OPC_W-1:0]   ir_opc, opc_q, opc_d;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [OPC_W-1:0]   alu_q;
  logic               run_q;
  state_e             boundary;
  logic               unused_ir_bits;

  assign ir_opc         = IR[IR_W-1 -: OPC_W];
  assign unused_ir_bits = ^IR[IR_W-OPC_W-1:0];
  assign boundary       = Stop ? S_HALT : S_T0;
  // Unary ops drive the ALU in T3, before opc_q has captured the opcode.
  assign opc_d          = (state_q == S_T2) ? ir_opc : opc_q;

  opcode_class_dec u_dec (
    .opcode_i (ir_opc),
    .cls_o    (ir_cls)
  );

  function automatic logic [CTRL_W-1:0] ctrl_of(state_e s);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (s)
      S_T0:                c = cb(C_PCOUT) | cb(C_MARIN) | cb(C_INCPC) | cb(C_ZLOWIN);
      S_T1:                c = cb(C_ZLOWOUT) | cb(C_PCIN) | cb(C_READ) | cb(C_MDRIN);
      S_T2:                c = cb(C_MDROUT) | cb(C_IRIN);
      S_R3, S_I3:          c = cb(C_GRB) | cb(C_ROUT) | cb(C_YIN);
      S_R4:                c = cb(C_GRC) | cb(C_ROUT) | cb(C_ZLOWIN);
      S_R5, S_I5, S_LDI5,
      S_U4:                c = cb(C_ZLOWOUT) | cb(C_GRA) | cb(C_RIN);
      S_I4, S_A4:          c = cb(C_COUT) | cb(C_ZLOWIN);
      S_M3:                c = cb(C_GRA) | cb(C_ROUT) | cb(C_YIN);
      S_M4:                c = cb(C_GRB) | cb(C_ROUT) | cb(C_ZHIGHIN) | cb(C_ZLOWIN);
      S_M5:                c = cb(C_ZLOWOUT) | cb(C_LOIN);
      S_M6:                c = cb(C_ZHIGHOUT) | cb(C_HIIN);
      S_U3:                c = cb(C_GRB) | cb(C_ROUT) | cb(C_ZLOWIN);
      S_A3:                c = cb(C_GRB) | cb(C_BAOUT) | cb(C_YIN);
      S_LD5, S_ST5:        c = cb(C_ZLOWOUT) | cb(C_MARIN);
      S_LD6:               c = cb(C_READ) | cb(C_MDRIN);
      S_LD7:               c = cb(C_MDROUT) | cb(C_GRA) | cb(C_RIN);
      S_ST6:               c = cb(C_GRA) | cb(C_ROUT) | cb(C_MDRIN);
      S_ST7:               c = cb(C_WRITE);
      default:             c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [OPC_W-1:0] alu_of(state_e s, logic [OPC_W-1:0] opc);
    logic [OPC_W-1:0] a;
    a = '0;
    case (s)
      S_R4, S_I4, S_M4, S_U3: a = opc;
      S_A4:                   a = OPC_W'(OP_ADD);
      default:                a = '0;
    endcase
    return a;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (Mem_ready) state_d = S_T2;
      S_T2: begin
        case (ir_cls)
          CL_RTYPE:           state_d = S_R3;
          CL_IMM:             state_d = S_I3;
          CL_MULDIV:          state_d = S_M3;
          CL_UNARY:           state_d = S_U3;
          CL_LD, CL_LDI,
          CL_ST:              state_d = S_A3;
          CL_HALT:            state_d = S_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
          CL_BAD:             state_d = S_HALT;
`endif
          default:            state_d = boundary;
        endcase
      end
      S_R3:   state_d = S_R4;
      S_R4:   state_d = S_R5;
      S_I3:   state_d = S_I4;
      S_I4:   state_d = S_I5;
      S_M3:   state_d = S_M4;
      S_M4:   state_d = S_M5;
      S_M5:   state_d = S_M6;
      S_U3:   state_d = S_U4;
      S_A3:   state_d = S_A4;
      S_A4: begin
        case (cls_q)
          CL_LDI:  state_d = S_LDI5;
          CL_LD:   state_d = S_LD5;
          default: state_d = S_ST5;
        endcase
      end
      S_LD5:  state_d = S_LD6;
      S_LD6:  if (Mem_ready) state_d = S_LD7;
      S_ST5:  state_d = S_ST6;
      S_ST6:  state_d = S_ST7;
      S_ST7:  if (Mem_ready) state_d = boundary;
      S_R5, S_I5, S_M6, S_U4,
      S_LDI5, S_LD7: state_d = boundary;
      default: state_d = S_HALT;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic ill_q;
  assign Illegal = ill_q;
`else
  assign Illegal = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      alu_q   <= '0;
      run_q   <= 1'b0;
      opc_q   <= '0;
      cls_q   <= CL_NOP;
`ifdef ILLEGAL_OP_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      alu_q   <= alu_of(state_d, opc_d);
      run_q   <= (state_d != S_IDLE) && (state_d != S_HALT);
      if (state_q == S_T2) begin
        opc_q <= ir_opc;
        cls_q <= ir_cls;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      if (state_q == S_T2 && ir_cls == CL_BAD) ill_q <= 1'b1;
`endif
    end
  end

  assign ctrl   = ctrl_q;
  assign alu_op = alu_q;
  assign Run    = run_q;

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Hard-wired control unit that sequences the DataPath through fetch, decode and execute T-steps. It produces every bus-select, register-load, ALU-op and memory strobe that the single-bus DataPath consumes. It replaces hand-driven bench stimulus with an opcode-driven Moore FSM. It sits beside DataPath and takes the IR contents plus a memory-ready handshake as inputs.

Parameters:
IR_W, 32, instruction width; IR[31:27]=opcode, [26:23]=Ra, [22:19]=Rb, [18:15]=Rc
OPC_W, 5, opcode and ALU-op width

Ports:
Clock  in  1  system clock; all state changes on its rising edge
Clear  in  1  asynchronous, active-low reset
IR  in  IR_W  current instruction register contents
Mem_ready  in  1  memory completed the Read or Write presented this cycle
Stop  in  1  request to halt at the next instruction boundary
ctrl  out  CTRL_W(25)  strobe bus; bit map is in the package
alu_op  out  OPC_W  ALU operation select
Run  out  1  high while executing; low in IDLE and HALT
Illegal  out  1  sticky flag for an undefined opcode (only with the macro)

Behaviour:
- ctrl bit map:
  - 0 PCout, 1 ZHighout, 2 Zlowout, 3 MDRout, 4 HIout, 5 LOout
  - 6 MARin, 7 PCin, 8 MDRin, 9 IRin, 10 Yin, 11 IncPC, 12 Read, 13 Write
  - 14 Gra, 15 Grb, 16 Grc, 17 Rin, 18 Rout, 19 BAout, 20 Cout
  - 21 HIin, 22 LOin, 23 ZHighIn, 24 ZLowIn
- Outputs: Moore-decoded from registered state and held for the whole cycle. alu_op is 0 except where stated.
- Reset: Clear low asynchronously forces state IDLE, ctrl=0, alu_op=0, Run=0, Illegal=0. This applies from any state, including mid-wait.
- IDLE: lasts one cycle after Clear deasserts, then T0.
- Fetch:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: Zlowout, PCin, Read, MDRin. Holds T1 while Mem_ready=0; re-loading PC from an unchanged Z is idempotent.
  - T2: MDRout, IRin. Next state is decoded from IR[31:27] as it will be latched. IR is sampled at the T2->T3 edge.
- R-type (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLowIn, alu_op=opcode.
  - T5: Zlowout, Gra, Rin.
- Immediate (addi 01100, andi 01101, ori 01110):
  - T3: Grb, Rout, Yin.
  - T4: Cout, ZLowIn, alu_op=opcode.
  - T5: Zlowout, Gra, Rin.
- mul 10000 / div 01111:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ZHighIn, ZLowIn, alu_op=opcode.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin.
- neg 10001 / not 10010:
  - T3: Grb, Rout, ZLowIn, alu_op=opcode.
  - T4: Zlowout, Gra, Rin.
- ld 00000 / ldi 00001 / st 00010, common steps:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ZLowIn, alu_op=ADD.
- ldi T5: Zlowout, Gra, Rin; done.
- ld:
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; holds while Mem_ready=0.
  - T7: MDRout, Gra, Rin.
- st:
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin.
  - T7: Write; holds while Mem_ready=0.
- nop 11010: returns to T0 after T2.
- halt 11011: goes to HALT; Run=0, ctrl=0 until reset.
- Instruction boundary: the last step of every instruction goes to T0, or to HALT if Stop=1 on that cycle. Stop is ignored elsewhere.
- Simultaneous Mem_ready and Stop in the final wait state: the transfer completes and the block goes to HALT.
- Undefined opcodes without the macro: treated as nop.
- Run=1 in every T-state.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an undefined opcode at T2 goes to HALT and sets Illegal=1. Illegal stays set until Clear.
- Undefined: undefined opcodes behave as nop, and Illegal is tied 0.

Decomposition:
- Package datapath_ctrl_pkg holds:
  - opcode constants (OP_LD ... OP_HALT);
  - ctrl bit indices and CTRL_W=25;
  - the state enum (IDLE, T0-T7 per class, HALT).
- One natural sub-module: opcode_class_dec, combinational, mapping opcode to class {RTYPE, IMM, MULDIV, UNARY, LD, LDI, ST, NOP, HALT, BAD}.

Test Plan:
- Reset, then IR=0x321B8000 (or R4,R3,R7) with Mem_ready tied 1:
  - T0-T5 in 6 cycles;
  - T4 shows alu_op=00110 with Grc, Rout and ZLowIn set;
  - T5 shows Zlowout, Gra and Rin set;
  - next cycle is T0.
- IR=opcode 10000 (mul): T5 asserts only Zlowout and LOin; T6 asserts only ZHighout and HIin; 7 cycles per instruction.
- ld with Mem_ready low for 3 cycles in T6: Read and MDRin are held 4 cycles, then T7 asserts MDRout, Gra and Rin.
- st followed by Stop=1 during T7 with Mem_ready=1: Write pulses once, the next state is HALT, Run=0 and ctrl=0.
- Clear pulled low mid-T1 wait: all outputs are 0 immediately; after release, IDLE lasts 1 cycle, then T0 (PCout, MARin, IncPC, ZLowIn).
- IR opcode 11111:
  - with the macro: HALT and Illegal=1;
  - without: returns to T0 after T2 and Illegal=0.
